// File: rtl/cc_compare_tracker_pkg.sv
// Shared types and constants for the compare tracker.
// Flag patterns are ordered {gt, lt, eq}.
package cc_compare_tracker_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int DEF_DATAWIDTH  = 8;
   localparam int DEF_COUNTWIDTH = 8;
   localparam int DEF_WINDOW     = 16;

   localparam logic [2:0] FLAG_GT = 3'b100;
   localparam logic [2:0] FLAG_LT = 3'b010;
   localparam logic [2:0] FLAG_EQ = 3'b001;

endpackage

// File: rtl/cc_event_counter.sv
// Up-counter with synchronous clear (priority) and enable.
module cc_event_counter #(
   parameter int NUMBER_COUNTWIDTH = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clr_i,
   input  logic                         en_i,
   output logic [NUMBER_COUNTWIDTH-1:0] count_o
);

   logic [NUMBER_COUNTWIDTH-1:0] count_q;
   logic [NUMBER_COUNTWIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + NUMBER_COUNTWIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/cc_compare_tracker.sv
// Windowed running-max / gt-lt-eq tracker closing the loop
// around an external magnitude comparator.
module cc_compare_tracker
   import cc_compare_tracker_pkg::*;
#(
   parameter int NUMBER_DATAWIDTH  = DEF_DATAWIDTH,
   parameter int NUMBER_COUNTWIDTH = DEF_COUNTWIDTH,
   parameter int NUMBER_WINDOW     = DEF_WINDOW
) (
   input  logic                         CC_COMPARE_TRACKER_CLOCK_50,
   input  logic                         CC_COMPARE_TRACKER_RESET_InHigh,
   input  logic                         CC_COMPARE_TRACKER_start_InHigh,
   input  logic                         CC_COMPARE_TRACKER_sampleValid_In,
   output logic                         CC_COMPARE_TRACKER_sampleReady_Out,
   input  logic [NUMBER_DATAWIDTH-1:0]  CC_COMPARE_TRACKER_sample_InBUS,
   input  logic                         CC_COMPARE_TRACKER_greaterthan_In,
   input  logic                         CC_COMPARE_TRACKER_lessthan_In,
   input  logic                         CC_COMPARE_TRACKER_equal_In,
   output logic [NUMBER_DATAWIDTH-1:0]  CC_COMPARE_TRACKER_ref_OutBUS,
   output logic [NUMBER_DATAWIDTH-1:0]  CC_COMPARE_TRACKER_max_OutBUS,
   output logic [NUMBER_COUNTWIDTH-1:0] CC_COMPARE_TRACKER_gtCount_OutBUS,
   output logic [NUMBER_COUNTWIDTH-1:0] CC_COMPARE_TRACKER_ltCount_OutBUS,
   output logic [NUMBER_COUNTWIDTH-1:0] CC_COMPARE_TRACKER_eqCount_OutBUS,
   output logic                         CC_COMPARE_TRACKER_done_Out,
   output logic                         CC_COMPARE_TRACKER_flagError_Out
);

   localparam int DW = NUMBER_DATAWIDTH;
   localparam int CW = NUMBER_COUNTWIDTH;

   if (NUMBER_WINDOW < 2 || NUMBER_WINDOW > (2 ** CW) - 1) begin : g_bad_window
      $error("NUMBER_WINDOW out of range for NUMBER_COUNTWIDTH");
   end

   logic clk;
   logic rst;
   assign clk = CC_COMPARE_TRACKER_CLOCK_50;
   assign rst = CC_COMPARE_TRACKER_RESET_InHigh;

   state_e state_q, state_d;

   logic [DW-1:0] ref_q, ref_d;
   logic [DW-1:0] max_q, max_d;
   logic [CW-1:0] gtr_q, gtr_d;
   logic [CW-1:0] ltr_q, ltr_d;
   logic [CW-1:0] eqr_q, eqr_d;
   logic          err_q, err_d;

   logic          ready;
   logic          xfer;
   logic          clr;
   logic          last;
   logic          gt_en, lt_en, eq_en, smp_en;
   logic [2:0]    flags;
   logic [CW-1:0] gt_cnt, lt_cnt, eq_cnt, smp_cnt;

   assign xfer  = CC_COMPARE_TRACKER_sampleValid_In & ready;
   assign clr   = (state_q == IDLE) & CC_COMPARE_TRACKER_start_InHigh;
   assign flags = {CC_COMPARE_TRACKER_greaterthan_In,
                   CC_COMPARE_TRACKER_lessthan_In,
                   CC_COMPARE_TRACKER_equal_In};

   cc_event_counter #(.NUMBER_COUNTWIDTH(CW)) u_gt_cnt (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(gt_en), .count_o(gt_cnt)
   );
   cc_event_counter #(.NUMBER_COUNTWIDTH(CW)) u_lt_cnt (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(lt_en), .count_o(lt_cnt)
   );
   cc_event_counter #(.NUMBER_COUNTWIDTH(CW)) u_eq_cnt (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(eq_en), .count_o(eq_cnt)
   );
   cc_event_counter #(.NUMBER_COUNTWIDTH(CW)) u_smp_cnt (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(smp_en), .count_o(smp_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (CC_COMPARE_TRACKER_start_InHigh) state_d = FIRST;
         FIRST:   if (xfer) state_d = RUN;
         RUN:     if (last) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready                       = (state_q == FIRST) | (state_q == RUN);
      CC_COMPARE_TRACKER_done_Out = (state_q == DONE);
   end

   // Result capture uses post-update values so the last sample counts.
   always_comb begin
      ref_d  = ref_q;
      err_d  = err_q;
      max_d  = max_q;
      gtr_d  = gtr_q;
      ltr_d  = ltr_q;
      eqr_d  = eqr_q;
      gt_en  = 1'b0;
      lt_en  = 1'b0;
      eq_en  = 1'b0;
      smp_en = 1'b0;
      last   = 1'b0;
      if (clr) begin
         ref_d = '0;
         err_d = 1'b0;
      end
      if (xfer && state_q == FIRST) begin
         ref_d  = CC_COMPARE_TRACKER_sample_InBUS;
         smp_en = 1'b1;
      end
      if (xfer && state_q == RUN) begin
         smp_en = 1'b1;
         case (flags)
            FLAG_GT: begin
               ref_d = CC_COMPARE_TRACKER_sample_InBUS;
               gt_en = 1'b1;
            end
            FLAG_LT: lt_en = 1'b1;
            FLAG_EQ: eq_en = 1'b1;
            default: err_d = 1'b1;
         endcase
         last = (smp_cnt == CW'(NUMBER_WINDOW - 1));
      end
      if (last) begin
         max_d = ref_d;
         gtr_d = gt_cnt + CW'(gt_en);
         ltr_d = lt_cnt + CW'(lt_en);
         eqr_d = eq_cnt + CW'(eq_en);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_q <= '0;
         max_q <= '0;
         gtr_q <= '0;
         ltr_q <= '0;
         eqr_q <= '0;
         err_q <= 1'b0;
      end else begin
         ref_q <= ref_d;
         max_q <= max_d;
         gtr_q <= gtr_d;
         ltr_q <= ltr_d;
         eqr_q <= eqr_d;
         err_q <= err_d;
      end
   end

   assign CC_COMPARE_TRACKER_sampleReady_Out = ready;
   assign CC_COMPARE_TRACKER_ref_OutBUS      = ref_q;
   assign CC_COMPARE_TRACKER_max_OutBUS      = max_q;
   assign CC_COMPARE_TRACKER_gtCount_OutBUS  = gtr_q;
   assign CC_COMPARE_TRACKER_ltCount_OutBUS  = ltr_q;
   assign CC_COMPARE_TRACKER_eqCount_OutBUS  = eqr_q;
   assign CC_COMPARE_TRACKER_flagError_Out   = err_q;

endmodule

// File: tb/tb_cc_compare_tracker.sv
// Bench for cc_compare_tracker: comparator modelled in the loop,
// results checked against a max/count reference model.
module tb_cc_compare_tracker;

   localparam int DW  = 8;
   localparam int CW  = 8;
   localparam int WIN = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          valid = 1'b0;
   logic [DW-1:0] sample = '0;
   logic          gt, lt, eq;
   logic          ready, done, ferr;
   logic [DW-1:0] refo, maxo;
   logic [CW-1:0] gtc, ltc, eqc;
   logic          force_en = 1'b0;
   logic [2:0]    force_val = 3'b000;

   always #5 clk = ~clk;

   assign {gt, lt, eq} = force_en ? force_val
                                  : {sample > refo, sample < refo, sample == refo};

   cc_compare_tracker #(
      .NUMBER_DATAWIDTH(DW), .NUMBER_COUNTWIDTH(CW), .NUMBER_WINDOW(WIN)
   ) dut (
      .CC_COMPARE_TRACKER_CLOCK_50(clk),
      .CC_COMPARE_TRACKER_RESET_InHigh(rst),
      .CC_COMPARE_TRACKER_start_InHigh(start),
      .CC_COMPARE_TRACKER_sampleValid_In(valid),
      .CC_COMPARE_TRACKER_sampleReady_Out(ready),
      .CC_COMPARE_TRACKER_sample_InBUS(sample),
      .CC_COMPARE_TRACKER_greaterthan_In(gt),
      .CC_COMPARE_TRACKER_lessthan_In(lt),
      .CC_COMPARE_TRACKER_equal_In(eq),
      .CC_COMPARE_TRACKER_ref_OutBUS(refo),
      .CC_COMPARE_TRACKER_max_OutBUS(maxo),
      .CC_COMPARE_TRACKER_gtCount_OutBUS(gtc),
      .CC_COMPARE_TRACKER_ltCount_OutBUS(ltc),
      .CC_COMPARE_TRACKER_eqCount_OutBUS(eqc),
      .CC_COMPARE_TRACKER_done_Out(done),
      .CC_COMPARE_TRACKER_flagError_Out(ferr)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   int smp[WIN];
   int m_ref, m_gt, m_lt, m_eq;
   bit m_err;
   logic [2:0] bad_pat[5] = '{3'b000, 3'b110, 3'b101, 3'b011, 3'b111};

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("first_ready", ready, 1);
      check("first_ferr", ferr, 0);
   endtask

   // gap_mode: 0 none, 1 two idle cycles before each later sample, 2 random
   task automatic feed(input int gap_mode, input int err_idx, input bit hold_start);
      int g;
      m_ref = 0; m_gt = 0; m_lt = 0; m_eq = 0; m_err = 0;
      for (int i = 0; i < WIN; i++) begin
         g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((i == 0) ? 0 : 2)
                                                   : $urandom_range(0, 2);
         repeat (g) begin
            valid  = 1'b0;
            sample = DW'($urandom);
            check("gap_ready", ready, 1);
            check("gap_done", done, 0);
            @(negedge clk);
         end
         check("ref_live", refo, m_ref);
         valid     = 1'b1;
         sample    = DW'(smp[i]);
         force_en  = (i == err_idx);
         force_val = bad_pat[$urandom_range(0, 4)];
         if (hold_start && i > 0) start = 1'b1;
         @(negedge clk);
         if (i == 0) m_ref = smp[i];
         else if (i == err_idx) m_err = 1;
         else if (smp[i] > m_ref) begin m_gt++; m_ref = smp[i]; end
         else if (smp[i] < m_ref) m_lt++;
         else m_eq++;
      end
      valid    = 1'b0;
      force_en = 1'b0;
      check("done_pulse", done, 1);
      check("done_ready", ready, 0);
      check("res_max", maxo, m_ref);
      check("res_gt", gtc, m_gt);
      check("res_lt", ltc, m_lt);
      check("res_eq", eqc, m_eq);
      check("res_ferr", ferr, m_err);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_ready", ready, 0);
      check("hold_max", maxo, m_ref);
      check("hold_ferr", ferr, m_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check("rst_ready", ready, 0);
      check("rst_ref", refo, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("noop_done", done, 0);
         check("noop_ready", ready, 0);
      end
      check("noop_max", maxo, 0);
      check("noop_counts", {gtc, ltc, eqc}, 0);
      check("noop_ferr", ferr, 0);

      // directed window, back-to-back
      smp = '{5, 9, 9, 3};
      do_start();
      feed(0, -1, 0);
      check("dir_max9", maxo, 9);
      check("dir_lt1", ltc, 1);

      // same samples with valid gaps
      do_start();
      feed(1, -1, 0);

      // illegal flags on the 2nd sample
      do_start();
      feed(0, 1, 0);
      check("err_sum", 32'(gtc) + 32'(ltc) + 32'(eqc), 2);
      check("err_flag", ferr, 1);

      // randomized windows
      repeat (25) begin
         foreach (smp[k]) smp[k] = $urandom_range(0, 15);
         do_start();
         feed(2, ($urandom_range(0, 3) == 0) ? $urandom_range(1, WIN - 1) : -1, 0);
      end

      // start held from RUN through DONE into IDLE
      foreach (smp[k]) smp[k] = $urandom_range(1, 200);
      do_start();
      feed(0, 2, 1);
      @(negedge clk);
      start = 1'b0;
      check("restart_ready", ready, 1);
      check("restart_ferr", ferr, 0);
      check("restart_ref", refo, 0);
      foreach (smp[k]) smp[k] = $urandom_range(0, 255);
      feed(2, -1, 0);

      // asynchronous reset mid-window
      smp = '{7, 12, 1, 1};
      do_start();
      valid = 1'b1; sample = 8'd7;
      @(negedge clk);
      sample = 8'd12;
      @(negedge clk);
      valid = 1'b0;
      check("pre_rst_ref", refo, 12);
      #2 rst = 1'b1;
      #1;
      check("arst_ref", refo, 0);
      check("arst_max", maxo, 0);
      check("arst_counts", {gtc, ltc, eqc}, 0);
      check("arst_ready", ready, 0);
      check("arst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_done", done, 0);
         check("post_rst_ready", ready, 0);
      end
      smp = '{0, 0, 0, 0};
      do_start();
      feed(0, -1, 0);
      check("zero_eq3", eqc, 3);
      check("zero_max", maxo, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
